// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM encoding,
// parity-type constants and the DATA-state watchdog limit.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Cycles the controller tolerates in DATA before declaring the serializer stuck.
  function automatic int wdog_limit(input int width_data);
    return width_data + 2;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR-reduction of the word, inverted for odd parity.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int WIDTH_DATA = 8
) (
  input  logic [WIDTH_DATA-1:0] word_i,
  input  logic                  type_i,
  output logic                  par_o
);

  assign par_o = (^word_i) ^ (type_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_controller.sv
// UART frame controller: start bit, data via an external serializer,
// optional parity, stop bit, with a watchdog on the serializer handshake.
module uart_tx_controller
  import uart_tx_pkg::*;
#(
  parameter int WIDTH_DATA = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH_DATA-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic [WIDTH_DATA-1:0] DATA_HOLD,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int                WD_W    = $clog2(WIDTH_DATA + 3);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(wdog_limit(WIDTH_DATA) - 1);

  tx_state_e             state_q;
  logic [WIDTH_DATA-1:0] data_q;
  logic                  par_bit_q;
  logic                  par_en_q;
  logic [WD_W-1:0]       wdog_q;
  logic                  err_q;
  logic                  par_d;

  parity_calc #(
    .WIDTH_DATA(WIDTH_DATA)
  ) u_parity (
    .word_i(P_DATA),
    .type_i(PAR_TYP),
    .par_o (par_d)
  );

  // Handshake: DATA_VALID has no ready; a word is taken only in IDLE or STOP
  // (BUSY low, or the last frame cycle) and is ignored in every other state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, STOP: begin
          if (DATA_VALID) begin
            data_q    <= P_DATA;
            par_bit_q <= par_d;
            par_en_q  <= PAR_EN;
            state_q   <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        START: begin
          wdog_q  <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (ser_done) begin
            state_q <= par_en_q ? PARITY : STOP;
          end else if (wdog_q == WD_LAST) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        PARITY:  state_q <= STOP;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    BUSY   = 1'b1;
    ser_en = 1'b0;
    case (state_q)
      IDLE:   BUSY   = 1'b0;
      START:  TX_OUT = 1'b0;
      DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
      end
      PARITY: TX_OUT = par_bit_q;
      STOP:   TX_OUT = 1'b1;
      default: BUSY  = 1'b0;
    endcase
  end

  assign DATA_HOLD = data_q;
  assign ERR       = err_q;

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA, default 8, giving the data word width in bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port P_DATA, input, WIDTH_DATA bits: parallel word to transmit.
REQ-006 The block SHALL have port DATA_VALID, input, 1 bit: P_DATA is valid this cycle.
REQ-007 The block SHALL have port PAR_EN, input, 1 bit: parity bit enable.
REQ-008 The block SHALL have port PAR_TYP, input, 1 bit: parity type, 0 = even, 1 = odd.
REQ-009 The block SHALL have port ser_done, input, 1 bit: the serializer is on its last data bit.
REQ-010 The block SHALL have port ser_data, input, 1 bit: the current serialized data bit.
REQ-011 The block SHALL have port DATA_HOLD, output, WIDTH_DATA bits: latched word that drives the serializer's P_DATA.
REQ-012 The block SHALL have port ser_en, output, 1 bit: serializer enable.
REQ-013 The block SHALL have port TX_OUT, output, 1 bit: serial line.
REQ-014 The block SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-015 The block SHALL have port ERR, output, 1 bit: one-cycle pulse on serializer timeout.

Function
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and the outputs SHALL be a Moore decode of the registered state.
REQ-017 In IDLE: TX_OUT=1, BUSY=0, ser_en=0; DATA_VALID=1 SHALL latch P_DATA into DATA_HOLD, latch PAR_EN/PAR_TYP and the computed parity, then go to START.
REQ-018 START SHALL last exactly 1 cycle with TX_OUT=0, BUSY=1, ser_en=0, then go to DATA.
REQ-019 DATA SHALL drive ser_en=1, TX_OUT=ser_data and BUSY=1, leaving on the cycle ser_done=1 for PARITY if latched PAR_EN=1, else STOP.
REQ-020 PARITY SHALL last exactly 1 cycle with TX_OUT=latched parity bit and BUSY=1, then go to STOP.
REQ-021 The parity bit SHALL be the XOR-reduction of the latched word when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-022 STOP SHALL last exactly 1 cycle with TX_OUT=1 and BUSY=1; DATA_VALID=1 in STOP SHALL latch a new word and go to START (back-to-back), otherwise go to IDLE.
REQ-023 DATA_VALID SHALL be ignored in START, DATA and PARITY, and DATA_HOLD SHALL stay stable throughout a frame.
REQ-024 Frame length SHALL be WIDTH_DATA+2 cycles without parity and WIDTH_DATA+3 cycles with parity, with the data sent LSB first.
REQ-025 A watchdog counter SHALL count cycles spent in DATA; if it reaches WIDTH_DATA+2 without ser_done, the FSM SHALL go to IDLE and pulse ERR for 1 cycle.
REQ-026 The watchdog counter width SHALL be $clog2(WIDTH_DATA+3) bits, and it SHALL clear on every DATA entry.
REQ-027 PAR_EN/PAR_TYP changes mid-frame SHALL NOT affect the current frame.

Reset
REQ-028 RST=1 SHALL, asynchronously, force: state=IDLE, DATA_HOLD=0, parity=0, latched PAR_EN=0, watchdog=0, TX_OUT=1, BUSY=0, ser_en=0, ERR=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no ERR pulse, and the line SHALL idle high from the reset cycle onward.
REQ-030 After RST deassertion, the first DATA_VALID SHALL be accepted in the next IDLE cycle.

Structure
REQ-031 The state encoding (3-bit enum), the parity-type constants (EVEN=0, ODD=1) and the watchdog limit function SHALL live in shared package uart_tx_pkg.
REQ-032 Parity computation SHALL be a separate combinational sub-module parity_calc (inputs: word, type; output: bit).
REQ-033 The serializer SHALL remain external, connected via DATA_HOLD, ser_en, ser_done and ser_data.

Verification
REQ-034 P_DATA=0x3C, PAR_EN=0 -> TX_OUT over 10 cycles = 0,0,0,1,1,1,1,0,0,1; BUSY high for exactly 10 cycles.
REQ-035 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 in cycle 10, then stop=1; with PAR_TYP=1 -> parity bit 1.
REQ-036 DATA_VALID held high with 0x55 then 0xAA -> second START immediately follows the first STOP; BUSY never drops between frames.
REQ-037 ser_done forced 0 in DATA -> ERR pulses once after 10 DATA cycles (WIDTH_DATA=8), state returns to IDLE, TX_OUT=1.
REQ-038 RST pulsed in DATA cycle 4 -> TX_OUT=1, BUSY=0, ser_en=0 immediately; a new 0x0F frame after release transmits correctly.
REQ-039 DATA_VALID with 0xFF asserted during DATA -> ignored; DATA_HOLD unchanged and the frame completes with the original word.
